// File: rtl/clock_divider_monitor.sv
// clock_divider_monitor
//   Checks a divided clock (sampled as data in the clk_i domain) against the
//   expected ratio DIV_N. Every period and high time is measured in clk_i
//   cycles. The monitor locks after LOCK_COUNT consecutive good periods. Once
//   locked, a bad period or a stall sets a sticky error.
//
// Ports
//   clk_i           source clock (the monitored divider runs from it)
//   reset_i         asynchronous active-high reset
//   div_clk_i       divided clock under test, sampled as data
//   clear_i         synchronous: clear error and restart acquisition
//   period_o        last measured period in clk_i cycles
//   high_o          high samples within the last measured period
//   period_valid_o  one-cycle pulse when period_o/high_o update
//   locked_o        high while locked
//   error_o         sticky fault flag
module clock_divider_monitor #(
  parameter int unsigned DIV_N      = 3,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             div_clk_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             error_o
);

  localparam int unsigned GoodW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] PeriodExp = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0] HighMin   = CNT_W'(DIV_N / 2);
  localparam logic [CNT_W-1:0] HighMax   = CNT_W'((DIV_N + 1) / 2);
  // pcnt sitting at 2*DIV_N without a rise would step to 2*DIV_N+1: a stall.
  localparam logic [CNT_W-1:0] StallCnt  = CNT_W'(2 * DIV_N);
  localparam logic [GoodW-1:0] GoodLast  = GoodW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked, StFault} state_e;

  state_e           state_q, state_d;
  logic             s0_q, s1_q;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [GoodW-1:0] good_q, good_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;

  logic rise;
  logic period_good;
  logic stall;

  always_comb begin
    rise        = s0_q & ~s1_q;
    period_good = (pcnt_q == PeriodExp) && (hcnt_q >= HighMin) && (hcnt_q <= HighMax);
    stall       = ~rise && (pcnt_q == StallCnt);

    state_d  = state_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    error_d  = error_q;

    // Free-running measurement counters, restarted by every rise.
    if (rise) begin
      pcnt_d = CNT_W'(1);
      hcnt_d = CNT_W'(1);
    end else begin
      pcnt_d = (pcnt_q == CntMax) ? pcnt_q : pcnt_q + CNT_W'(1);
      hcnt_d = (s0_q && (hcnt_q != CntMax)) ? hcnt_q + CNT_W'(1) : hcnt_q;
    end

    // The first rise after IDLE only aligns the counters; it is not a measurement.
    if (rise && (state_q != StIdle)) begin
      period_d = pcnt_q;
      high_d   = hcnt_q;
      valid_d  = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (rise) state_d = StAcquire;
      end
      StAcquire: begin
        if (rise) begin
          if (period_good) begin
            if (good_q == GoodLast) begin
              state_d = StLocked;
              good_d  = '0;
            end else begin
              good_d = good_q + GoodW'(1);
            end
          end else begin
            good_d = '0;
          end
        end
      end
      StLocked: begin
        if ((rise && !period_good) || stall) begin
          state_d = StFault;
          error_d = 1'b1;
        end
      end
      StFault: begin
        error_d = 1'b1;
      end
    endcase

    // Clear wins over any same-cycle rise or fault; the last measurement is kept.
    if (clear_i) begin
      state_d  = StIdle;
      error_d  = 1'b0;
      good_d   = '0;
      pcnt_d   = '0;
      hcnt_d   = '0;
      period_d = period_q;
      high_d   = high_q;
      valid_d  = 1'b0;
    end

    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_q     <= div_clk_i;
      s1_q     <= s0_q;
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  assign period_o       = period_q;
  assign high_o         = high_q;
  assign period_valid_o = valid_q;
  assign locked_o       = locked_q;
  assign error_o        = error_q;

endmodule

// File: doc/clock_divider_monitor.md
# clock_divider_monitor

Checks a divided clock against its expected division ratio, sampling it in the source clock domain. Sits directly downstream of a fixed divider such as `clock_divider3`: the divider's `clk_o` drives `div_clk_i`, and both blocks share `clk_i`/`reset_i`. It measures every period and high time in `clk_i` cycles and declares lock after a run of good periods. After lock, a wrong period, a duty violation or a stall raises a sticky error. Used for bring-up checks and runtime self-test of the clock tree.

## Interface
- `DIV_N`, default 3: expected division ratio; legal range is ≥2.
- `CNT_W`, default 8: width of the counters and measurement outputs. Must satisfy 2*DIV_N+1 < 2^CNT_W.
- `LOCK_COUNT`, default 4: number of consecutive good periods required to lock; legal range is ≥1.
- `clk_i`  in  1  source clock; the monitored divider runs from this clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `div_clk_i`  in  1  divided clock under test. It is treated as data and is never used as a clock.
- `clear_i`  in  1  synchronous; clears the error and restarts acquisition.
- `period_o`  out  CNT_W  last measured period, in `clk_i` cycles.
- `high_o`  out  CNT_W  number of samples in which `div_clk_i` was high during the last measured period.
- `period_valid_o`  out  1  one-cycle pulse when `period_o`/`high_o` update.
- `locked_o`  out  1  high while in the LOCKED state.
- `error_o`  out  1  sticky fault flag.

## Operation
- **Sampling.** `s0` registers `div_clk_i` on each `clk_i` rising edge; `s1` registers `s0`. A rise is detected when `s0 & ~s1`.
  - No synchronizer is used: the input is from the same domain. A divider output changing on the `clk_i` falling edge still has half a cycle of margin.
- **Period counter `pcnt`.**
  - On a rise cycle: `period_o <= pcnt`, then `pcnt <= 1`.
  - Otherwise: `pcnt <= pcnt+1`, saturating at 2^CNT_W-1.
- **High counter `hcnt`.**
  - On a rise cycle: `high_o <= hcnt`, then `hcnt <= 1`.
  - Otherwise: `hcnt <= hcnt + s0`, saturating.
- **Good period.** A period is good when both hold:
  - `period == DIV_N`;
  - `floor(DIV_N/2) <= high <= ceil(DIV_N/2)`.
- **FSM states:** IDLE, ACQUIRE, LOCKED, FAULT.
  - **IDLE.** The first rise moves to ACQUIRE. This rise does not update `period_o`/`high_o` and does not pulse `period_valid_o`, because `pcnt` was not aligned.
  - **ACQUIRE.** On each rise, `period_o`/`high_o` update and `period_valid_o` pulses.
    - Good period: `good_cnt++`. When `good_cnt` reaches `LOCK_COUNT`, go to LOCKED.
    - Bad period: `good_cnt <= 0` and stay in ACQUIRE. No error is raised.
  - **LOCKED.** On each rise, `period_o`/`high_o` update and `period_valid_o` pulses.
    - A bad period moves to FAULT and sets `error_o`.
    - A stall also moves to FAULT and sets `error_o`: `pcnt` reaching 2*DIV_N+1 with no rise, i.e. no rise within 2*DIV_N cycles.
  - **FAULT.** Measurement continues and `period_valid_o` still pulses on each rise. `error_o` stays high and the state is held until `clear_i`.
- **`clear_i` (any state):** go to IDLE; `error_o`, `good_cnt`, `pcnt` and `hcnt` are cleared. `period_o`/`high_o` keep their values.
  - `clear_i` has priority over a same-cycle rise; that rise is not counted.
  - It also has priority over a same-cycle fault; no error is set.
- **Simultaneous bad period and stall in LOCKED:** a single transition to FAULT.
- **Reset values:**
  - registers `s0`, `s1`: 0;
  - counters `pcnt`, `hcnt`, `good_cnt`: 0;
  - outputs `period_o`, `high_o`, `period_valid_o`, `locked_o`, `error_o`: 0;
  - state: IDLE.

## Timing
- **Measurement latency:** let the `div_clk_i` rise first be captured into `s0` at `clk_i` edge k. Then `period_o`, `high_o`, `period_valid_o`, the state, `locked_o` and `error_o` all update at edge k+1.
- **Lock timing:** `locked_o` rises on the same edge as the `period_valid_o` pulse of the LOCK_COUNT-th consecutive good period.
- **Error timing:**
  - For a bad period, `error_o` rises on the same edge as that period's `period_valid_o` pulse.
  - For a stall, `error_o` rises on the edge where `pcnt` would take the value 2*DIV_N+1; `locked_o` falls on that same edge.
- **Output registration:** all outputs are registered; there is no combinational input-to-output path.
- **Asynchronous reset:** assertion forces reset values immediately, including mid-period and mid-acquisition.

## Test plan
- **Lock on divide-by-3:** DIV_N=3, driven by a divide-by-3 source; release reset after 10 ns (10 ns `clk_i` period).
  - Every `period_valid_o` shows `period_o`=3 and `high_o` of 1 or 2.
  - `locked_o`=1 at the 4th valid pulse; `error_o`=0 thereafter for 200 ns.
- **Stall while locked:** after lock, hold `div_clk_i`=0.
  - `error_o`=1 and `locked_o`=0 exactly when `pcnt` hits 7 (6 cycles after the last rise plus one).
- **Clear after fault:** pulse `clear_i` for 1 cycle, then resume the divider.
  - `error_o`=0 on the next edge; the state re-enters IDLE.
  - The first rise gives no pulse; `locked_o`=1 again after 4 good periods.
- **Wrong ratio:** feed a divide-by-4 stream with DIV_N=3.
  - Every valid shows `period_o`=4; `locked_o` and `error_o` stay 0 indefinitely.
- **Glitch after lock:** inject one period of length 2 (high 1).
  - `period_o`=2 and `error_o`=1 on that valid pulse.
  - `error_o` holds through subsequent good periods.
- **Duty violation and reset mid-acquire:**
  - DIV_N=4, period 4 with 1 high sample: the period is bad and `good_cnt` restarts.
  - Assert `reset_i` after 2 good periods: all outputs are 0 immediately, and lock needs 4 fresh good periods.
